// File: rtl/uart_pkg.sv
// Shared types for the configurable UART: parity modes, transmitter states
// and the per-frame configuration captured when a word is accepted.
package uart_pkg;

  localparam int MaxDivWidth = 32;

  typedef enum logic [1:0] {
    ParityNone = 2'b00,
    ParityEven = 2'b01,
    ParityOdd  = 2'b10
  } parity_e;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop1  = 3'd4;
  localparam logic [2:0] StStop2  = 3'd5;
  localparam logic [2:0] StBreak  = 3'd6;

  typedef enum logic [2:0] {
    TxIdle   = StIdle,
    TxStart  = StStart,
    TxData   = StData,
    TxParity = StParity,
    TxStop1  = StStop1,
    TxStop2  = StStop2,
    TxBreak  = StBreak
  } tx_state_e;

  typedef struct packed {
    logic [MaxDivWidth-1:0] div;
    parity_e                parity;
    logic                   stop2;
  } frame_cfg_t;

  // Code 2'b11 is treated as "no parity" so every input pattern is defined.
  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      2'b01:   return ParityEven;
      2'b10:   return ParityOdd;
      default: return ParityNone;
    endcase
  endfunction

  function automatic int unsigned frame_bits(input frame_cfg_t cfg,
                                             input int unsigned data_bits);
    return 1 + data_bits + ((cfg.parity != ParityNone) ? 1 : 0) + (cfg.stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts a loaded divisor down to zero and strobes on zero,
// then reloads, giving one strobe every div_i+1 cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DivWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                restart_i,
  input  logic [DivWidth-1:0] div_i,
  output logic                stb_o
);

  logic [DivWidth-1:0] cnt_q;

  // Restart aligns the first strobe to exactly one bit period after a frame starts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == '0)) begin
      cnt_q <= div_i;
    end else begin
      cnt_q <= cnt_q - DivWidth'(1);
    end
  end

  assign stb_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with break generation. Divisor,
// parity and stop-bit count are captured with each accepted word.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int   DataBits    = 8,
  parameter int   DivWidth    = 16,
  parameter logic DefaultIdle = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DataBits-1:0] data_i,
  input  logic [DivWidth-1:0] cfg_div_i,
  input  logic [1:0]          cfg_parity_i,
  input  logic                cfg_stop2_i,
  input  logic                break_i,
  output logic                busy_o,
  output logic                tx_o
);

  localparam int IdxWidth = $clog2(DataBits);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(DataBits - 1);

  tx_state_e           state_q, state_d;
  logic [IdxWidth-1:0] bit_idx_q, bit_idx_d;
  logic [DataBits-1:0] data_q;
  frame_cfg_t          cfg_q, cfg_in;
  logic                idle_rdy_q;
  logic                busy_q;
  logic                tx_q, tx_d;
  logic                line_bit;
  logic                parity_bit;
  logic                stb;
  logic                transfer;
  logic                last_stop;
  logic [DivWidth-1:0] baud_div;
  logic                unused_div;

  assign cfg_in.div    = MaxDivWidth'(cfg_div_i);
  assign cfg_in.parity = decode_parity(cfg_parity_i);
  assign cfg_in.stop2  = cfg_stop2_i;

  // Accepting during the final stop cycle lets the next start bit follow with no gap.
  assign last_stop = stb && (((state_q == TxStop1) && !cfg_q.stop2) || (state_q == TxStop2));
  assign ready_o   = ((state_q == TxIdle) && idle_rdy_q && !break_i) || last_stop;
  assign transfer  = valid_i && ready_o;

  assign baud_div   = transfer ? cfg_div_i : cfg_q.div[DivWidth-1:0];
  assign unused_div = |cfg_q.div;
  assign parity_bit = (^data_q) ^ (cfg_q.parity == ParityOdd);

  uart_baud_gen #(
    .DivWidth(DivWidth)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .restart_i(transfer),
    .div_i    (baud_div),
    .stb_o    (stb)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      TxIdle: begin
        if (transfer) begin
          state_d = TxStart;
        end else if (break_i) begin
          state_d = TxBreak;
        end
      end
      TxStart: begin
        if (stb) begin
          state_d = TxData;
        end
      end
      TxData: begin
        if (stb) begin
          if (bit_idx_q == LastIdx) begin
            bit_idx_d = '0;
            state_d   = (cfg_q.parity != ParityNone) ? TxParity : TxStop1;
          end else begin
            bit_idx_d = bit_idx_q + IdxWidth'(1);
          end
        end
      end
      TxParity: begin
        if (stb) begin
          state_d = TxStop1;
        end
      end
      TxStop1: begin
        if (stb) begin
          if (cfg_q.stop2) begin
            state_d = TxStop2;
          end else begin
            state_d = transfer ? TxStart : TxIdle;
          end
        end
      end
      TxStop2: begin
        if (stb) begin
          state_d = transfer ? TxStart : TxIdle;
        end
      end
      TxBreak: begin
        if (!break_i) begin
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // The pin level is derived from the next state so tx_o can come straight from a flop.
  always_comb begin
    line_bit = 1'b1;
    unique case (state_d)
      TxStart:  line_bit = 1'b0;
      TxData:   line_bit = data_q[bit_idx_d];
      TxParity: line_bit = parity_bit;
      TxBreak:  line_bit = 1'b0;
      default:  line_bit = 1'b1;
    endcase
    tx_d = line_bit ? DefaultIdle : ~DefaultIdle;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= TxIdle;
      bit_idx_q  <= '0;
      idle_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= DefaultIdle;
      data_q     <= '0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      idle_rdy_q <= 1'b1;
      busy_q     <= (state_d != TxIdle);
      tx_q       <= tx_d;
      if (transfer) begin
        data_q <= data_i;
        cfg_q  <= cfg_in;
      end
    end
  end

  assign busy_o = busy_q;
  assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: two lanes (8-bit and 7-bit data) whose
// accepted words are expanded into per-cycle expected line levels.
module tb_uart_tx_cfg;

  typedef struct {
    logic [8:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
  } frame_t;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) begin
        $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int DB = (g == 0) ? 8 : 7;

    logic          rst_n, valid, ready, busy, tx, brk, stop2;
    logic [DB-1:0] data;
    logic [15:0]   div;
    logic [1:0]    par;
    bit            done;
    frame_t        sb[$];

    uart_tx_cfg #(
      .DataBits   (DB),
      .DivWidth   (16),
      .DefaultIdle(1'b1)
    ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .valid_i     (valid),
      .ready_o     (ready),
      .data_i      (data),
      .cfg_div_i   (div),
      .cfg_parity_i(par),
      .cfg_stop2_i (stop2),
      .break_i     (brk),
      .busy_o      (busy),
      .tx_o        (tx)
    );

    task automatic idleCycles(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic waitIdle();
      int k = 0;
      while (busy && k < 2000) begin
        idleCycles(1);
        k++;
      end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic applyStimulus(input logic [DB-1:0] d, input logic [15:0] dv,
                                 input logic [1:0] p, input logic s2);
      int waited = 0;
      valid = 1'b1;
      data  = d;
      div   = dv;
      par   = p;
      stop2 = s2;
      #1;
      while (!ready) begin
        if (waited >= 2000) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL lane%0d accept: ready stayed %b, required 1", g, ready);
          valid = 1'b0;
          @(posedge clk);
          #1;
          return;
        end
        waited++;
        @(posedge clk);
        #2;
      end
      sb.push_back('{data: 9'(d), div: dv, par: p, stop2: s2});
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = DB'($urandom);
      div   = 16'($urandom_range(0, 15));
      par   = 2'($urandom);
      stop2 = 1'($urandom);
    endtask

    initial begin : stim
      int gap;
      rst_n = 1'b0;
      valid = 1'b0;
      brk   = 1'b0;
      data  = '0;
      div   = '0;
      par   = '0;
      stop2 = 1'b0;
      done  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idleCycles(1);

      if (DB == 8) begin
        applyStimulus(DB'(8'hA5), 16'd3, 2'b00, 1'b0);
        idleCycles(3);
        applyStimulus(DB'(8'hFF), 16'd2, 2'b10, 1'b0);
        applyStimulus(DB'(8'h00), 16'd2, 2'b10, 1'b0);
        idleCycles(2);
        applyStimulus(DB'(8'h3C), 16'd3, 2'b00, 1'b0);
        applyStimulus(DB'(8'hC3), 16'd9, 2'b00, 1'b0);
      end else begin
        applyStimulus(DB'(7'h03), 16'd0, 2'b01, 1'b1);
        idleCycles(2);
        applyStimulus(DB'(7'h55), 16'd1, 2'b11, 1'b1);
        applyStimulus(DB'(7'h7F), 16'd0, 2'b10, 1'b0);
      end
      waitIdle();

      brk = 1'b1;
      idleCycles(50);
      brk = 1'b0;
      idleCycles(3);

      applyStimulus(DB'($urandom), 16'd2, 2'b00, 1'b0);
      idleCycles(5);
      brk = 1'b1;
      idleCycles(60);
      brk = 1'b0;
      idleCycles(3);

      applyStimulus(DB'(8'h96), 16'd5, 2'b01, 1'b0);
      idleCycles(26);
      rst_n = 1'b0;
      idleCycles(1);
      rst_n = 1'b1;
      idleCycles(3);

      for (int i = 0; i < 40; i++) begin
        applyStimulus(DB'($urandom), 16'($urandom_range(0, 4)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        gap = $urandom_range(0, 3);
        if (gap == 3) begin
          waitIdle();
          brk = 1'b1;
          idleCycles($urandom_range(1, 4));
          brk = 1'b0;
          idleCycles(1);
        end else begin
          idleCycles(gap);
        end
      end
      waitIdle();
      idleCycles(5);
      done = 1'b1;
    end

    // Reference: each accepted word becomes a list of line levels, one per clock cycle.
    initial begin : mon
      logic   lvl[$];
      logic   bits[$];
      frame_t f;
      bit     brk_mode, armed, in_frame, last;
      logic   et, er, eb;
      int     ones;
      brk_mode = 1'b0;
      armed    = 1'b0;
      forever begin
        @(negedge clk);
        if (lvl.size() > 0) begin
          et       = lvl.pop_front();
          in_frame = 1'b1;
          last     = (lvl.size() == 0);
        end else begin
          et       = brk_mode ? 1'b0 : 1'b1;
          in_frame = 1'b0;
          last     = 1'b0;
        end
        eb = in_frame || brk_mode;
        er = (!in_frame && !brk_mode && armed && !brk) || last;
        checkOutput($sformatf("lane%0d_tx", g), tx, et);
        checkOutput($sformatf("lane%0d_busy", g), busy, eb);
        checkOutput($sformatf("lane%0d_ready", g), ready, er);

        if (!rst_n) begin
          lvl.delete();
          sb.delete();
          brk_mode = 1'b0;
          armed    = 1'b0;
        end else begin
          armed = 1'b1;
          if (sb.size() > 0) begin
            f = sb.pop_front();
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < DB; i++) bits.push_back(f.data[i]);
            ones = $countones(f.data);
            if (f.par == 2'b01) bits.push_back(ones[0]);
            if (f.par == 2'b10) bits.push_back(~ones[0]);
            bits.push_back(1'b1);
            if (f.stop2) bits.push_back(1'b1);
            foreach (bits[b]) begin
              for (int r = 0; r <= int'(f.div); r++) lvl.push_back(bits[b]);
            end
          end else if (brk_mode) begin
            brk_mode = brk;
          end else if (!in_frame && brk) begin
            brk_mode = 1'b1;
          end
        end
      end
    end
  end

  initial begin : summary
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (g_lane[0].done && g_lane[1].done) break;
    end
    if (!(g_lane[0].done && g_lane[1].done)) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL completion: lanes done %b%b, required 11",
               g_lane[1].done, g_lane[0].done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
